ap_hs_perf_monitor: RTL and testbench
=====================================

# ap_hs_perf_monitor

Synthesizable, parametrised per-channel performance monitor for `ap_ctrl_hs`/`ap_ctrl_chain` block-level handshakes. It observes `NUM_CH` HLS modules in parallel and tracks transaction count, last/min/max start-to-done latency and `ap_continue` back-pressure stall cycles for each. Results are read through a registered, channel-selected readout port. It sits beside the dataflow region in both on-chip builds and co-simulation, replacing testbench-only status dumping with hardware counters.

## Interface
- `NUM_CH`, default 4: number of monitored channels, 1..16.
- `CNT_W`, default 32: width of every counter, 8..48.
- `SEL_W`, default `$clog2(NUM_CH)` (min 1): width of the readout select.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global count enable.
- `clear`  in  1  synchronous clear of all counters and FSMs.
- `ch_start`  in  NUM_CH  per-channel `ap_start`.
- `ch_done`  in  NUM_CH  per-channel `ap_done`.
- `ch_continue`  in  NUM_CH  per-channel `ap_continue` (tie 1 for `ap_ctrl_hs`).
- `rd_req`  in  1  readout request pulse.
- `rd_sel`  in  SEL_W  channel to read.
- `rd_valid`  out  1  readout data valid, one-cycle pulse.
- `rd_txn_count`  out  CNT_W  completed transactions.
- `rd_last_lat`  out  CNT_W  latency of the most recent transaction.
- `rd_min_lat` / `rd_max_lat`  out  CNT_W  latency extremes.
- `rd_stall`  out  CNT_W  cumulative stall cycles.
- `ch_busy`  out  NUM_CH  channel FSM not in IDLE.

## Operation
- Each channel has an independent three-state FSM: IDLE, RUN, HOLD.
- Reset state is IDLE.
- Notation: `s`, `d`, `c` are that channel's start, done and continue bits.
- IDLE:
  - `s=0`: stay.
  - `s=1`: begin a transaction with latency accumulator `lat`=1.
  - Same cycle `d&c`: complete, stay IDLE.
  - Same cycle `d&!c`: go to HOLD, stall+1.
  - Otherwise: go to RUN.
- RUN:
  - Each cycle: `lat`+1.
  - `d&c`: complete, go to IDLE.
  - `d&!c`: stall+1, go to HOLD.
- HOLD:
  - Each cycle: `lat`+1.
  - `c=0`: stall+1.
  - `c=1`: complete, go to IDLE. `d` is treated as held.
- Complete:
  - `txn_count`+1, `last_lat`←`lat`.
  - `min_lat`←min(`min_lat`, `lat`); `max_lat`←max(`max_lat`, `lat`).
- `ch_start` is ignored outside IDLE, including pipelined restarts after `ap_ready`.
- Back-to-back transactions: the next one begins in the IDLE cycle after completion.
- `enable=0`:
  - FSMs keep tracking state.
  - No counter, `lat` or stall update occurs.
  - A completion while disabled updates nothing.
- All counters saturate at all-ones and never wrap.
- `clear=1`:
  - All FSMs go to IDLE.
  - Counters, `lat`, `last_lat` and `max_lat` are set to 0; `min_lat` is set to all-ones.
  - `clear` wins over any simultaneous event; that event is discarded.
- Readout:
  - On `rd_req`, the selected channel's values (post-update of that same edge excluded) are registered.
  - `rd_sel >= NUM_CH` returns all zeros with `rd_valid=1`.

## Timing
- Reset values:
  - `rd_valid=0`, all `rd_*` data 0, `ch_busy=0`.
  - Internal `min_lat` = all-ones.
- Readout latency: `rd_req` at edge N produces `rd_valid=1` and data for cycle N+1 only.
- Returned data reflects counter values as they were before edge N.
- Back-to-back `rd_req` gives back-to-back `rd_valid`.
- `ch_busy` is registered from the FSM state, with no combinational input path.
- Reset mid-transaction: all state is lost and nothing is reported for the interrupted transaction.

## Configuration
- `AP_HS_PERF_MINMAX_EN` defined: min/max latency registers and comparators are built per channel.
- Not defined:
  - Those registers and comparators are not built.
  - `rd_min_lat` and `rd_max_lat` are tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Ch0: `s` high 1 cycle, `d&c` 9 cycles later. Then read ch0 → `txn_count`=1, `last_lat`=10, min=max=10, `stall`=0.
- Ch1:
  - Stimulus: `d` at lat 5 with `c=0` for 3 cycles, then `c=1`.
  - Read → `stall`=3, `last_lat`=8.
  - Also: `s` and `d&c` in the same IDLE cycle → `last_lat`=1.
- Three ch2 transactions with latencies 4, 12, 7 → `txn_count`=3, min=4, max=12, `last_lat`=7. Without the macro, min=max=0.
- `CNT_W`=8: 300 transactions → `txn_count`=255. `clear` asserted on a completion cycle → count 0, min=0xFF on readout.
- `enable=0` across an entire 6-cycle transaction, then enabled → `txn_count` unchanged, FSM back in IDLE.
- `reset` pulsed low while all 4 channels are in RUN → `ch_busy`=0 and all readouts 0 immediately. `rd_sel=5` with `NUM_CH`=4 → zeros with `rd_valid`.

Source files
------------

// File: rtl/ap_hs_perf_monitor.sv
// ap_hs_perf_monitor: per-channel ap_ctrl_hs/ap_ctrl_chain transaction, latency and stall counters.
// Latency: rd_valid and readout data one cycle after rd_req; ch_busy is a registered state decode.
// Backpressure: observe-only, never stalls the monitored handshakes; optional macro AP_HS_PERF_MINMAX_EN builds min/max.
module ap_hs_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_txn_count,
  output logic [CNT_W-1:0]  rd_last_lat,
  output logic [CNT_W-1:0]  rd_min_lat,
  output logic [CNT_W-1:0]  rd_max_lat,
  output logic [CNT_W-1:0]  rd_stall,
  output logic [NUM_CH-1:0] ch_busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-channel results gathered for the readout mux.
  logic [NUM_CH-1:0][CNT_W-1:0] txn_q;
  logic [NUM_CH-1:0][CNT_W-1:0] last_q;
  logic [NUM_CH-1:0][CNT_W-1:0] min_q;
  logic [NUM_CH-1:0][CNT_W-1:0] max_q;
  logic [NUM_CH-1:0][CNT_W-1:0] stall_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic             busy;
    logic             s;
    logic             d;
    logic             c;
    logic             cmpl;
    logic             stall_hit;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] lat_nxt;
    logic [CNT_W-1:0] txn;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] stall;

    assign s = ch_start[i];
    assign d = ch_done[i];
    assign c = ch_continue[i];

    // State register; FSM keeps tracking the handshake even while counting is disabled.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (clear) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        state <= state_nxt;
        busy  <= (state_nxt != ST_IDLE);
      end
    end

    // Next state: start only accepted in IDLE; done is treated as held once in HOLD.
    always_comb begin
      state_nxt = state;
      case (state)
        ST_IDLE: begin
          if (s) begin
            if (d && c)  state_nxt = ST_IDLE;
            else if (d)  state_nxt = ST_HOLD;
            else         state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (d) state_nxt = c ? ST_IDLE : ST_HOLD;
        end
        ST_HOLD: begin
          if (c) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Outputs: the latency including this cycle, plus completion and stall strobes.
    always_comb begin
      lat_nxt   = lat;
      cmpl      = 1'b0;
      stall_hit = 1'b0;
      case (state)
        ST_IDLE: begin
          if (s) begin
            lat_nxt   = CNT_W'(1);
            cmpl      = d & c;
            stall_hit = d & ~c;
          end
        end
        ST_RUN: begin
          lat_nxt   = sat_inc(lat);
          cmpl      = d & c;
          stall_hit = d & ~c;
        end
        ST_HOLD: begin
          lat_nxt   = sat_inc(lat);
          cmpl      = c;
          stall_hit = ~c;
        end
        default: ;
      endcase
    end

    // Counter update; clear wins, and nothing moves while disabled.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        lat   <= '0;
        txn   <= '0;
        last  <= '0;
        stall <= '0;
      end else if (clear) begin
        lat   <= '0;
        txn   <= '0;
        last  <= '0;
        stall <= '0;
      end else if (enable) begin
        lat <= lat_nxt;
        if (stall_hit) stall <= sat_inc(stall);
        if (cmpl) begin
          txn  <= sat_inc(txn);
          last <= lat_nxt;
        end
      end
    end

`ifdef AP_HS_PERF_MINMAX_EN
    logic [CNT_W-1:0] min_r;
    logic [CNT_W-1:0] max_r;

    // Latency extremes; min starts at all-ones so the first completion always lands.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        min_r <= '1;
        max_r <= '0;
      end else if (clear) begin
        min_r <= '1;
        max_r <= '0;
      end else if (enable && cmpl) begin
        if (lat_nxt < min_r) min_r <= lat_nxt;
        if (lat_nxt > max_r) max_r <= lat_nxt;
      end
    end

    assign min_q[i] = min_r;
    assign max_q[i] = max_r;
`else
    assign min_q[i] = '0;
    assign max_q[i] = '0;
`endif

    assign txn_q[i]   = txn;
    assign last_q[i]  = last;
    assign stall_q[i] = stall;
    assign ch_busy[i] = busy;
  end

  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;

  assign rd_idx      = IDX_W'(rd_sel);
  assign rd_in_range = (32'(rd_sel) < NUM_CH);

  // Readout register: captures pre-edge counter values; out-of-range select returns zeros.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid     <= 1'b0;
      rd_txn_count <= '0;
      rd_last_lat  <= '0;
      rd_min_lat   <= '0;
      rd_max_lat   <= '0;
      rd_stall     <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req && rd_in_range) begin
        rd_txn_count <= txn_q[rd_idx];
        rd_last_lat  <= last_q[rd_idx];
        rd_min_lat   <= min_q[rd_idx];
        rd_max_lat   <= max_q[rd_idx];
        rd_stall     <= stall_q[rd_idx];
      end else begin
        rd_txn_count <= '0;
        rd_last_lat  <= '0;
        rd_min_lat   <= '0;
        rd_max_lat   <= '0;
        rd_stall     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ap_hs_perf_monitor.sv
// Directed bench for ap_hs_perf_monitor: a 32-bit and an 8-bit instance share all stimulus.
// Expected values are hand-computed from the handshake sequences applied.
// Build with AP_HS_PERF_MINMAX_EN to check the min/max registers as well.
module tb_ap_hs_perf_monitor;

`ifdef AP_HS_PERF_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] ch_start = 4'h0;
  logic [3:0] ch_done = 4'h0;
  logic [3:0] ch_continue = 4'hF;
  logic       rd_req = 1'b0;
  logic [2:0] rd_sel = 3'd0;

  logic        a_valid;
  logic [31:0] a_txn, a_last, a_min, a_max, a_stall;
  logic [3:0]  a_busy;
  logic        b_valid;
  logic [7:0]  b_txn, b_last, b_min, b_max, b_stall;
  logic [3:0]  b_busy;

  int n_vec = 0;
  int n_bad = 0;

  ap_hs_perf_monitor #(.NUM_CH(4), .CNT_W(32), .SEL_W(3)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ch_start(ch_start), .ch_done(ch_done), .ch_continue(ch_continue),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(a_valid),
    .rd_txn_count(a_txn), .rd_last_lat(a_last), .rd_min_lat(a_min),
    .rd_max_lat(a_max), .rd_stall(a_stall), .ch_busy(a_busy)
  );

  ap_hs_perf_monitor #(.NUM_CH(4), .CNT_W(8), .SEL_W(3)) u_dut8 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ch_start(ch_start), .ch_done(ch_done), .ch_continue(ch_continue),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(b_valid),
    .rd_txn_count(b_txn), .rd_last_lat(b_last), .rd_min_lat(b_min),
    .rd_max_lat(b_max), .rd_stall(b_stall), .ch_busy(b_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transaction of the given latency on one channel, continue left high.
  task automatic run_txn(input int ch, input int lat);
    ch_start[ch] = 1'b1;
    if (lat == 1) begin
      ch_done[ch] = 1'b1;
      tick();
      ch_start[ch] = 1'b0;
      ch_done[ch]  = 1'b0;
    end else begin
      tick();
      ch_start[ch] = 1'b0;
      repeat (lat - 2) tick();
      ch_done[ch] = 1'b1;
      tick();
      ch_done[ch] = 1'b0;
    end
  endtask

  // Single-cycle readout request; outputs are valid on return.
  task automatic read_ch(input logic [2:0] sel);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_valid", a_valid, 0);
    check("reset_txn", a_txn, 0);
    check("reset_min", a_min, 0);
    check("reset_busy", a_busy, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Ch0: start, done&continue nine cycles later -> latency 10
    ch_start[0] = 1'b1;
    tick();
    ch_start[0] = 1'b0;
    check("ch0_busy_run", a_busy, 4'b0001);
    repeat (8) tick();
    ch_done[0] = 1'b1;
    tick();
    ch_done[0] = 1'b0;
    check("ch0_busy_done", a_busy, 4'b0000);
    read_ch(3'd0);
    check("ch0_valid", a_valid, 1);
    check("ch0_txn", a_txn, 1);
    check("ch0_last", a_last, 10);
    check("ch0_min", a_min, MM ? 10 : 0);
    check("ch0_max", a_max, MM ? 10 : 0);
    check("ch0_stall", a_stall, 0);
    tick();
    check("ch0_valid_pulse", a_valid, 0);

    // Ch1: done at lat 5 with continue low three cycles -> stall 3, latency 8
    ch_start[1] = 1'b1;
    tick();
    ch_start[1] = 1'b0;
    repeat (3) tick();
    ch_done[1] = 1'b1;
    ch_continue[1] = 1'b0;
    tick();
    check("ch1_busy_hold", a_busy, 4'b0010);
    ch_done[1] = 1'b0;
    tick();
    tick();
    ch_continue[1] = 1'b1;
    tick();
    check("ch1_busy_done", a_busy, 4'b0000);
    read_ch(3'd1);
    check("ch1_txn", a_txn, 1);
    check("ch1_last", a_last, 8);
    check("ch1_stall", a_stall, 3);
    check("ch1_min", a_min, MM ? 8 : 0);

    // Ch1: start and done&continue in the same IDLE cycle -> latency 1
    run_txn(1, 1);
    check("ch1_same_busy", a_busy, 4'b0000);
    read_ch(3'd1);
    check("ch1_same_txn", a_txn, 2);
    check("ch1_same_last", a_last, 1);
    check("ch1_same_min", a_min, MM ? 1 : 0);
    check("ch1_same_max", a_max, MM ? 8 : 0);
    check("ch1_same_stall", a_stall, 3);

    // Ch2: back-to-back latencies 4, 12, 7
    run_txn(2, 4);
    run_txn(2, 12);
    run_txn(2, 7);
    read_ch(3'd2);
    check("ch2_txn", a_txn, 3);
    check("ch2_min", a_min, MM ? 4 : 0);
    check("ch2_max", a_max, MM ? 12 : 0);
    check("ch2_last", a_last, 7);

    // Back-to-back reads, second one out of range
    rd_req = 1'b1;
    rd_sel = 3'd2;
    tick();
    check("b2b_valid0", a_valid, 1);
    check("b2b_txn0", a_txn, 3);
    rd_sel = 3'd5;
    tick();
    check("oor_valid", a_valid, 1);
    check("oor_txn", a_txn, 0);
    check("oor_last", a_last, 0);
    rd_req = 1'b0;
    tick();
    check("oor_valid_drop", a_valid, 0);

    // Ch3: 300 single-cycle transactions -> 8-bit counter saturates
    ch_start[3] = 1'b1;
    ch_done[3] = 1'b1;
    repeat (300) tick();
    ch_start[3] = 1'b0;
    ch_done[3] = 1'b0;
    read_ch(3'd3);
    check("sat_txn32", a_txn, 300);
    check("sat_txn8", b_txn, 8'hFF);
    check("sat_last8", b_last, 1);

    // Clear on a completion cycle: completion discarded, min back to all-ones
    ch_start[3] = 1'b1;
    ch_done[3] = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ch_start[3] = 1'b0;
    ch_done[3] = 1'b0;
    read_ch(3'd3);
    check("clr_txn8", b_txn, 0);
    check("clr_min8", b_min, MM ? 8'hFF : 8'h00);
    check("clr_last8", b_last, 0);
    check("clr_txn32", a_txn, 0);
    check("clr_max32", a_max, 0);
    read_ch(3'd1);
    check("clr_stall_ch1", a_stall, 0);

    // Enable low across a 6-cycle transaction on ch0
    enable = 1'b0;
    ch_start[0] = 1'b1;
    tick();
    ch_start[0] = 1'b0;
    check("dis_busy_run", a_busy, 4'b0001);
    repeat (4) tick();
    ch_done[0] = 1'b1;
    tick();
    ch_done[0] = 1'b0;
    enable = 1'b1;
    check("dis_busy_idle", a_busy, 4'b0000);
    read_ch(3'd0);
    check("dis_txn", a_txn, 0);
    check("dis_last", a_last, 0);
    run_txn(0, 3);
    read_ch(3'd0);
    check("reen_txn", a_txn, 1);
    check("reen_last", a_last, 3);

    // Reset while all four channels run
    run_txn(1, 3);
    ch_start = 4'hF;
    tick();
    ch_start = 4'h0;
    tick();
    check("all_run_busy", a_busy, 4'hF);
    read_ch(3'd1);
    check("pre_rst_txn", a_txn, 1);
    check("pre_rst_last", a_last, 3);
    reset = 1'b0;
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_txn", a_txn, 0);
    check("rst_last", a_last, 0);
    check("rst_busy8", b_busy, 0);
    reset = 1'b1;
    tick();
    read_ch(3'd1);
    check("post_rst_txn", a_txn, 0);
    check("post_rst_last", a_last, 0);
    check("post_rst_min", a_min, MM ? 32'hFFFF_FFFF : 32'h0);
    check("post_rst_busy", a_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
